// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg : shared FSM state, width helpers and operand extension.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   // Widest value mac_ext can extend into; callers cast the result down.
   localparam int unsigned EXT_W = 64;

   function automatic int unsigned idx_w(input int unsigned size);
      return (size <= 2) ? 1 : $clog2(size);
   endfunction

   function automatic int unsigned dim_w(input int unsigned size);
      return $clog2(size + 1);
   endfunction

   // Sign- or zero-extend the low 'width' bits of operand to EXT_W bits.
   function automatic logic [EXT_W-1:0] mac_ext(input logic [EXT_W-1:0] operand,
                                                input int unsigned       width,
                                                input logic              signed_mode);
      logic [EXT_W-1:0] mask;
      logic             fill;
      mask = (EXT_W'(1) << width) - EXT_W'(1);
      fill = signed_mode & (|(operand & (EXT_W'(1) << (width - 1))));
      return fill ? (operand | ~mask) : (operand & mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_mac_cell.sv
// ---------------------------------------------------------------------------
// tpu_mac_cell : one accumulator with clear/enable; APPROX_MUL_EN truncates
// operand LSBs before the multiply.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tpu_mac_cell
   import tpu_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ACC_WIDTH   = 32,
   parameter int APPROX_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc_next
);

   if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
      $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
   end
   if (APPROX_BITS < 0 || APPROX_BITS >= DATA_WIDTH) begin : g_bad_approx
      $error("APPROX_BITS must lie in 0..DATA_WIDTH-1");
   end

`ifdef APPROX_MUL_EN
   localparam logic [DATA_WIDTH-1:0] OP_MASK = ~DATA_WIDTH'((1 << APPROX_BITS) - 1);
`else
   localparam logic [DATA_WIDTH-1:0] OP_MASK = '1;
`endif

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] a_ext, b_ext, prod;

   // Extending both operands to ACC_WIDTH first gives the extended full
   // product modulo 2^ACC_WIDTH directly.
   assign a_ext = ACC_WIDTH'(mac_ext(EXT_W'(a & OP_MASK), DATA_WIDTH, signed_mode));
   assign b_ext = ACC_WIDTH'(mac_ext(EXT_W'(b & OP_MASK), DATA_WIDTH, signed_mode));
   assign prod  = a_ext * b_ext;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + prod;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_next = acc_d;

endmodule

`default_nettype wire

// File: rtl/tpu_matmul_stream.sv
// ---------------------------------------------------------------------------
// tpu_matmul_stream : buffered C=A*B with SIZE x SIZE parallel MACs and a
// row-major result stream. Optional macro APPROX_MUL_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tpu_matmul_stream
   import tpu_pkg::*;
#(
   parameter  int SIZE        = 4,
   parameter  int DATA_WIDTH  = 8,
   parameter  int ACC_WIDTH   = 32,
   parameter  int APPROX_BITS = 2,
   localparam int IW          = idx_w(SIZE),
   localparam int DW          = dim_w(SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic                  load_sel,
   input  logic [IW-1:0]         load_row,
   input  logic [IW-1:0]         load_col,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [DW-1:0]         cfg_m,
   input  logic [DW-1:0]         cfg_n,
   input  logic [DW-1:0]         cfg_k,
   input  logic                  cfg_signed,
   input  logic                  cfg_accum,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data,
   output logic [IW-1:0]         out_row,
   output logic [IW-1:0]         out_col,
   output logic                  out_last
);

   state_e               state_q, state_d;
   logic [DW-1:0]        m_q, m_d, n_q, n_d, k_q, k_d, k_cnt_q, k_cnt_d;
   logic                 sgn_q, sgn_d;
   logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
   logic [IW-1:0]        out_row_q, out_row_d, out_col_q, out_col_d;

   logic [DATA_WIDTH-1:0] a_q [SIZE][SIZE];
   logic [DATA_WIDTH-1:0] a_d [SIZE][SIZE];
   logic [DATA_WIDTH-1:0] b_q [SIZE][SIZE];
   logic [DATA_WIDTH-1:0] b_d [SIZE][SIZE];
   logic [ACC_WIDTH-1:0]  c_next [SIZE][SIZE];

   logic          load_ok, cfg_ok, fire, row_end, nxt_last, cell_clr, computing;
   logic [IW-1:0] nxt_row, nxt_col, k_idx;
   logic [SIZE-1:0] row_act, col_act;

   assign computing = (state_q == ST_COMPUTE);
   assign k_idx     = k_cnt_q[IW-1:0];

   for (genvar i = 0; i < SIZE; i++) begin : g_row
      assign row_act[i] = 32'(m_q) > i;
      assign col_act[i] = 32'(n_q) > i;
      for (genvar j = 0; j < SIZE; j++) begin : g_col
         tpu_mac_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .APPROX_BITS (APPROX_BITS)
         ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr         (cell_clr),
            .en          (computing & row_act[i] & col_act[j]),
            .signed_mode (sgn_q),
            .a           (a_q[i][k_idx]),
            .b           (b_q[k_idx][j]),
            .acc_next    (c_next[i][j])
         );
      end
   end

   always_comb begin
      load_ok = (state_q == ST_IDLE) && load_valid
                && (32'(load_row) < SIZE) && (32'(load_col) < SIZE);
      cfg_ok  = (cfg_m != '0) && (32'(cfg_m) <= SIZE)
                && (cfg_n != '0) && (32'(cfg_n) <= SIZE)
                && (cfg_k != '0) && (32'(cfg_k) <= SIZE);
      fire    = out_valid_q && out_ready;
      row_end = (DW'(out_col_q) == n_q - DW'(1));
      nxt_row = row_end ? out_row_q + IW'(1) : out_row_q;
      nxt_col = row_end ? '0 : out_col_q + IW'(1);
      nxt_last = (DW'(nxt_row) == m_q - DW'(1)) && (DW'(nxt_col) == n_q - DW'(1));

      state_d     = state_q;
      m_d         = m_q;
      n_d         = n_q;
      k_d         = k_q;
      k_cnt_d     = k_cnt_q;
      sgn_d       = sgn_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      cell_clr    = 1'b0;
      a_d         = a_q;
      b_d         = b_q;

      // The write lands at the same edge a start is taken, so a job launched
      // alongside a load already sees the new operand.
      if (load_ok) begin
         if (load_sel) b_d[load_row][load_col] = load_data;
         else          a_d[load_row][load_col] = load_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               m_d   = cfg_m;
               n_d   = cfg_n;
               k_d   = cfg_k;
               sgn_d = cfg_signed;
               if (cfg_ok) begin
                  state_d  = ST_COMPUTE;
                  k_cnt_d  = '0;
                  busy_d   = 1'b1;
                  cell_clr = !cfg_accum;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_COMPUTE: begin
            if (k_cnt_q == k_q - DW'(1)) begin
               // c_next carries the final MAC, so element (0,0) is ready now.
               state_d     = ST_DRAIN;
               out_valid_d = 1'b1;
               out_row_d   = '0;
               out_col_d   = '0;
               out_last_d  = (m_q == DW'(1)) && (n_q == DW'(1));
               out_data_d  = c_next[0][0];
            end else begin
               k_cnt_d = k_cnt_q + DW'(1);
            end
         end
         ST_DRAIN: begin
            if (fire) begin
               if (out_last_q) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
               end else begin
                  out_row_d  = nxt_row;
                  out_col_d  = nxt_col;
                  out_last_d = nxt_last;
                  out_data_d = c_next[nxt_row][nxt_col];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         m_q         <= '0;
         n_q         <= '0;
         k_q         <= '0;
         k_cnt_q     <= '0;
         sgn_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
               a_q[i][j] <= '0;
               b_q[i][j] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         n_q         <= n_d;
         k_q         <= k_d;
         k_cnt_q     <= k_cnt_d;
         sgn_q       <= sgn_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         a_q         <= a_d;
         b_q         <= b_d;
      end
   end

   assign load_ready = (state_q == ST_IDLE);
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_data   = out_data_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;

endmodule

`default_nettype wire

// File: tb/tb_tpu_matmul_stream.sv
// ---------------------------------------------------------------------------
// tb_tpu_matmul_stream : directed jobs, expected C pushed to a scoreboard and
// popped by a stream monitor.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tpu_matmul_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid, load_ready, load_sel;
   logic [1:0]  load_row, load_col;
   logic [7:0]  load_data;
   logic [2:0]  cfg_m, cfg_n, cfg_k;
   logic        cfg_signed, cfg_accum, start;
   logic        busy, done, err, out_valid, out_ready, out_last;
   logic [31:0] out_data;
   logic [1:0]  out_row, out_col;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [36:0] sb [$];
   logic        bp_en = 1'b0;
   logic        stall_pend = 1'b0;
   logic [36:0] held;
   logic [7:0]  mat_a [4][4];
   logic [7:0]  mat_b [4][4];
   logic [31:0] exp_c [4][4];

   always #5 clk = ~clk;

   tpu_matmul_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_sel   (load_sel),
      .load_row   (load_row),
      .load_col   (load_col),
      .load_data  (load_data),
      .cfg_m      (cfg_m),
      .cfg_n      (cfg_n),
      .cfg_k      (cfg_k),
      .cfg_signed (cfg_signed),
      .cfg_accum  (cfg_accum),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops expected {last,row,col,data} on each handshake and checks
   // that a stalled element is still presented unchanged one cycle later.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (stall_pend)
            chk("stall_hold", {27'd0, out_last, out_row, out_col, out_data}, {27'd0, held});
         if (out_ready) begin
            stall_pend = 1'b0;
            if (sb.size() == 0) begin
               chk("unexpected_out", {27'd0, out_last, out_row, out_col, out_data}, 64'hDEAD);
            end else begin
               chk("out_elem", {27'd0, out_last, out_row, out_col, out_data}, {27'd0, sb.pop_front()});
            end
         end else begin
            stall_pend = 1'b1;
            held = {out_last, out_row, out_col, out_data};
         end
      end else begin
         stall_pend = 1'b0;
      end
   end

   task automatic load_elem(input logic sel, input int r, input int c, input logic [7:0] d);
      load_valid = 1'b1;
      load_sel   = sel;
      load_row   = 2'(r);
      load_col   = 2'(c);
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic load_all();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            load_elem(1'b0, i, j, mat_a[i][j]);
            load_elem(1'b1, i, j, mat_b[i][j]);
         end
   endtask

   task automatic run_job(input int m, input int n, input int k, input logic sgn,
                          input logic accum, input logic chk_lat);
      int cnt;
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++)
            sb.push_back({(i == m - 1) && (j == n - 1), 2'(i), 2'(j), exp_c[i][j]});
      cfg_m = 3'(m); cfg_n = 3'(n); cfg_k = 3'(k);
      cfg_signed = sgn; cfg_accum = accum;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("load_ready_busy", 64'(load_ready), 64'd0);
      cnt = 0;
      while (!done && cnt < 300) begin
         tick();
         cnt++;
      end
      chk("done_seen", 64'(done), 64'd1);
      if (chk_lat) chk("done_latency", 64'(cnt), 64'(k + m * n));
      tick();
      chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
      load_data = '0; cfg_m = '0; cfg_n = '0; cfg_k = '0; cfg_signed = 1'b0;
      cfg_accum = 1'b0; start = 1'b0;
      repeat (2) tick();
      chk("reset_outputs", {57'd0, busy, done, err, out_valid, out_last, load_ready},
          {57'd0, 6'b000001});
      chk("reset_data", {28'd0, out_row, out_col, out_data}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Identity times B returns B; done at 4 + 16 cycles past the start edge.
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            mat_a[i][j] = (i == j) ? 8'd1 : 8'd0;
            mat_b[i][j] = 8'(i * 4 + j + 1);
            exp_c[i][j] = 32'(i * 4 + j + 1);
         end
      load_all();
      run_job(4, 4, 4, 1'b1, 1'b0, 1'b1);

      // 0xFF * 2: -2 when signed, 510 when unsigned.
      load_elem(1'b0, 0, 0, 8'hFF);
      load_elem(1'b1, 0, 0, 8'h02);
      exp_c[0][0] = 32'hFFFF_FFFE;
      run_job(1, 1, 1, 1'b1, 1'b0, 1'b1);
      exp_c[0][0] = 32'd510;
      run_job(1, 1, 1, 1'b0, 1'b0, 1'b1);

      // 2x3 by 3x1: [1 2 3; 4 5 6] * [7; 8; 9] = [50; 122].
      load_elem(1'b0, 0, 0, 8'd1); load_elem(1'b0, 0, 1, 8'd2); load_elem(1'b0, 0, 2, 8'd3);
      load_elem(1'b0, 1, 0, 8'd4); load_elem(1'b0, 1, 1, 8'd5); load_elem(1'b0, 1, 2, 8'd6);
      load_elem(1'b1, 0, 0, 8'd7); load_elem(1'b1, 1, 0, 8'd8); load_elem(1'b1, 2, 0, 8'd9);
      exp_c[0][0] = 32'd50; exp_c[1][0] = 32'd122;
      run_job(2, 1, 3, 1'b1, 1'b0, 1'b1);
      exp_c[0][0] = 32'd100; exp_c[1][0] = 32'd244;
      run_job(2, 1, 3, 1'b1, 1'b1, 1'b1);
      exp_c[0][0] = 32'd50; exp_c[1][0] = 32'd122;
      run_job(2, 1, 3, 1'b1, 1'b0, 1'b1);

      // Identity job again under random backpressure.
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_c[i][j] = 32'(i * 4 + j + 1);
      load_all();
      bp_en = 1'b1;
      run_job(4, 4, 4, 1'b1, 1'b0, 1'b0);
      bp_en = 1'b0;
      tick();

      // Rejected starts.
      cfg_m = 3'd4; cfg_n = 3'd4; cfg_k = 3'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_k0", {62'd0, err, busy}, 64'b10);
      tick();
      chk("err_pulse_end", 64'(err), 64'd0);
      cfg_m = 3'd5; cfg_k = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_m5", {62'd0, err, busy}, 64'b10);
      tick();

      // Reset in the middle of COMPUTE aborts without done and clears C.
      cfg_m = 3'd4; cfg_n = 3'd4; cfg_k = 3'd4; cfg_signed = 1'b0; cfg_accum = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("reset_abort_busy", 64'(busy), 64'd0);
      tick();
      chk("reset_abort_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("no_done_after_reset", 64'(done), 64'd0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_c[i][j] = 32'd0;
      run_job(4, 4, 1, 1'b0, 1'b1, 1'b1);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tpu_matmul_stream.md
Name: tpu_matmul_stream

Overview:
- Parametrised successor to the direct-array matrix unit.
- Operands are loaded element-wise through a valid/ready port into internal A/B buffers.
- Computes C = A×B for runtime dimensions M×K by K×N (each 1..SIZE), one k-step per cycle with all SIZE×SIZE MACs in parallel.
- Results stream out row-major on a valid/ready port.
- Sits between the host DMA/loader and the result writeback path; supports signed/unsigned operands and K-tiling by accumulation.

Parameters:
- SIZE, 4, max matrix dimension (rows/cols of A, B, C buffers).
- DATA_WIDTH, 8, operand width.
- ACC_WIDTH, 32, accumulator/output width; must be >= 2*DATA_WIDTH.
- APPROX_BITS, 2, operand LSBs zeroed when APPROX_MUL_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  operand write request.
- load_ready  out  1  high only in IDLE.
- load_sel  in  1  0=A, 1=B.
- load_row  in  IW  row index; IW=$clog2(SIZE), min 1.
- load_col  in  IW  column index.
- load_data  in  DATA_WIDTH  operand value.
- cfg_m, cfg_n, cfg_k  in  DW  dimensions; DW=$clog2(SIZE+1).
- cfg_signed  in  1  1=two's-complement operands, 0=unsigned.
- cfg_accum  in  1  1=keep prior C contents, 0=clear C on start.
- start  in  1  single-cycle launch.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected start.
- out_valid  out  1  result element valid.
- out_ready  in  1  consumer accepts.
- out_data  out  ACC_WIDTH  C element.
- out_row, out_col  out  IW  element indices.
- out_last  out  1  final element of job.

Behaviour:
- Clock/reset: clk; rst_n asynchronous, active-low. Reset sets state IDLE, busy/done/err/out_valid/out_last=0, out_data/out_row/out_col=0, and clears A, B, C buffers and counters.
- States: IDLE, COMPUTE, DRAIN.
- IDLE
  - load_ready=1. A handshake writes load_data to A or B[row][col].
  - A load with row or col >= SIZE is accepted but discarded.
  - start in IDLE latches cfg_*. Any of m/n/k == 0 or > SIZE gives err=1 next cycle and the block stays IDLE.
  - Otherwise: next state COMPUTE, k_cnt=0, busy=1 next cycle, C cleared if cfg_accum=0.
  - A same-cycle load and valid start: the load is written, then the job begins (load precedes job).
- COMPUTE, one cycle per k, for k_cnt in 0..cfg_k-1:
  - For all i<m, j<n: C[i][j] += ext(A[i][k]) * ext(B[k][j]). Elements outside m×n are untouched.
  - ext is sign- or zero-extension per latched cfg_signed. The full 2*DATA_WIDTH product is extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
  - After cycle k_cnt==cfg_k-1: go to DRAIN with out indices (0,0).
- DRAIN
  - out_valid=1. Elements are presented row-major over i<m, j<n.
  - out_data/row/col/last are held stable while out_valid && !out_ready.
  - out_last=1 on element (m-1, n-1).
  - Handshake on the last element: out_valid=0, done=1 for one cycle, busy=0, return to IDLE, all in the same cycle.
- Latency: start to first out_valid = cfg_k+1 cycles (1 cycle to register, cfg_k compute cycles). With out_ready tied high, done occurs at start + cfg_k + m*n + 1.
- start while busy is ignored (no err). load_valid outside IDLE sees load_ready=0; no write occurs.
- C persists after the job, so cfg_accum=1 on the next job extends the sum for K>SIZE tiling.
- Reset mid-job aborts immediately, with no done pulse. C is cleared.

Optional Feature:
- Macro APPROX_MUL_EN.
- When defined: the low APPROX_BITS bits of each operand are forced to 0 before the multiply (truncated approximate MAC). Everything else is unchanged.
- When undefined: the multiply is exact and APPROX_BITS is unused.

Decomposition:
- Package tpu_pkg holds:
  - state enum (IDLE/COMPUTE/DRAIN);
  - index/dim width helper functions;
  - function mac_ext(operand, signed_mode) performing extension.
- One sub-module, tpu_mac_cell: a single accumulator register with clear, enable, signed mode, and the APPROX_MUL_EN truncation.
- The top level instantiates SIZE×SIZE cells and holds the FSM, buffers and output sequencer.

Test Plan:
- Identity: load A=I4, B=[[1..4],[5..8],[9..12],[13..16]], m=n=k=4, signed, out_ready=1 -> 16 outputs equal B row-major; out_last on (3,3); done at cycle start+21.
- Signed/unsigned: A[0][0]=8'hFF, B[0][0]=8'h02, m=n=k=1 -> signed out_data=-2 (32'hFFFFFFFE); unsigned out_data=510.
- Non-square 2×3 by 3×1: m=2, k=3, n=1 -> exactly 2 outputs with correct dot products; done after the 2nd element handshake.
- Accumulate: run a job, then rerun with cfg_accum=1 and same operands -> every element doubles. A rerun with cfg_accum=0 restores single values.
- Backpressure: toggle out_ready randomly -> no lost or duplicated element; data/indices stable while stalled.
- Errors/reset: start with cfg_k=0 or cfg_m=SIZE+1 -> err pulse, busy stays 0. rst_n low mid-COMPUTE -> busy=0, no done, subsequent read of C (k=1 job with zero operands, accum=1) returns 0.
- Note: APPROX_MUL_EN build, APPROX_BITS=2: A=7, B=7 -> out_data=16.
